// File: rtl/regbank_pkg.sv
// regbank_pkg: shared widths, FSM encoding and read-latency limits for the register bank arbiter.
package regbank_pkg;
    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; a lone requester always wins, ties go to prio_i.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    input  logic       en_i,
    output logic [1:0] grant_o,
    output logic       next_prio_o
);
    assign grant_o     = !en_i ? 2'b00 : (&valid_i) ? (prio_i ? 2'b10 : 2'b01) : valid_i;
    assign next_prio_o = grant_o[0] ? 1'b1 : grant_o[1] ? 1'b0 : prio_i;
endmodule

// File: rtl/regbank_arb.sv
// regbank_arb: shares a single-port register bank between the UART command path (port 0)
// and the local host (port 1), one bank cycle per accepted request, read data routed to its owner.
module regbank_arb
    import regbank_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_wr,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_rvalid,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_wr,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_rvalid,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              rb_en,
    output logic              rb_we,
    output logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_wdata,
    input  logic [DATA_W-1:0] rb_rdata
);
    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("regbank_arb: RD_LAT must be within 1..4");
    end

    localparam logic [2:0] LAT = 3'(RD_LAT);

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [1:0]        grant;
    logic              next_prio;

    // No grant while reset is asserted: an accepted request would be silently discarded.
    rr_arb2 u_arb (
        .valid_i     ({req1_valid, req0_valid}),
        .prio_i      (prio_q),
        .en_i        (state_q == S_IDLE && rst_n),
        .grant_o     (grant),
        .next_prio_o (next_prio)
    );

    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            S_IDLE: if (|grant) begin
                state_d = S_ACCESS;
                prio_d  = next_prio;
                owner_d = grant[1];
                we_d    = grant[1] ? req1_wr    : req0_wr;
                addr_d  = grant[1] ? req1_addr  : req0_addr;
                wdata_d = grant[1] ? req1_wdata : req0_wdata;
            end
            S_ACCESS: begin
                state_d = we_q ? S_IDLE : S_RDWAIT;
                cnt_d   = 3'd1;
            end
            S_RDWAIT: if (cnt_q == LAT) begin
                state_d  = S_RESP;
                rdata0_d = owner_q ? rdata0_q : rb_rdata;
                rdata1_d = owner_q ? rb_rdata : rdata1_q;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prio_q   <= 1'b0;
            owner_q  <= 1'b0;
            cnt_q    <= 3'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign req0_ready  = grant[0];
    assign req1_ready  = grant[1];
    assign req0_rvalid = state_q == S_RESP && !owner_q;
    assign req1_rvalid = state_q == S_RESP && owner_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign rb_en       = state_q == S_ACCESS;
    assign rb_we       = we_q;
    assign rb_addr     = addr_q;
    assign rb_wdata    = wdata_q;
endmodule

// File: tb/tb_regbank_arb.sv
// tb_regbank_arb: scoreboard bench; stimulus queues expected grants, bank cycles and responses,
// a negedge monitor pops and compares them. Two instances cover RD_LAT=1 and RD_LAT=3.
module tb_regbank_arb;
    typedef struct {int c; logic [31:0] v;} exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       v0, v1, wr0, wr1, v3;
    logic [6:0] a0, a1, a3;
    logic [7:0] d0, d1;
    logic       rdy0, rdy1, rv0, rv1;
    logic [7:0] rd0, rd1;
    logic       rb_en, rb_we;
    logic [6:0] rb_addr;
    logic [7:0] rb_wdata, rb_rdata;
    logic       rdy3_0, rdy3_1, rv3_0, rv3_1;
    logic [7:0] rd3_0, rd3_1;
    logic       en3, we3;
    logic [6:0] addr3;
    logic [7:0] wd3, rdata3;

    regbank_arb #(.ADDR_W(7), .DATA_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v0), .req0_wr(wr0), .req0_addr(a0), .req0_wdata(d0),
        .req0_ready(rdy0), .req0_rvalid(rv0), .req0_rdata(rd0),
        .req1_valid(v1), .req1_wr(wr1), .req1_addr(a1), .req1_wdata(d1),
        .req1_ready(rdy1), .req1_rvalid(rv1), .req1_rdata(rd1),
        .rb_en(rb_en), .rb_we(rb_we), .rb_addr(rb_addr), .rb_wdata(rb_wdata), .rb_rdata(rb_rdata)
    );

    regbank_arb #(.ADDR_W(7), .DATA_W(8), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v3), .req0_wr(1'b0), .req0_addr(a3), .req0_wdata(8'h00),
        .req0_ready(rdy3_0), .req0_rvalid(rv3_0), .req0_rdata(rd3_0),
        .req1_valid(1'b0), .req1_wr(1'b0), .req1_addr(7'h00), .req1_wdata(8'h00),
        .req1_ready(rdy3_1), .req1_rvalid(rv3_1), .req1_rdata(rd3_1),
        .rb_en(en3), .rb_we(we3), .rb_addr(addr3), .rb_wdata(wd3), .rb_rdata(rdata3)
    );

    // Bank models: data is only valid in the cycle RD_LAT after the strobe, 0xEE otherwise.
    logic [7:0] mem [128];
    logic       bv;
    logic [7:0] bd;
    always @(posedge clk) begin
        if (rb_en && rb_we) mem[rb_addr] <= rb_wdata;
        bv <= rb_en && !rb_we;
        bd <= mem[rb_addr];
    end
    assign rb_rdata = bv ? bd : 8'hEE;

    logic [2:0] s3;
    always @(posedge clk) s3 <= !rst_n ? 3'b000 : {s3[1:0], en3 && !we3};
    assign rdata3 = s3[2] ? 8'h5C : 8'hEE;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q_g1[$], q_bk[$], q_r0[$], q_r1[$], q_g3[$], q_r3[$];
    exp_t e;
    int   tests = 0, fails = 0;
    logic quiet = 1'b0, chk_rst = 1'b0, done = 1'b0, fin = 1'b0;

    function automatic logic [31:0] bk(input logic w, input logic [6:0] a, input logic [7:0] d);
        return {16'h0, w, a, w ? d : 8'h00};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic miss(input string n);
        tests++;
        fails++;
        $display("FAIL %s: unexpected event, nothing queued (cycle %0d)", n, cyc);
    endtask

    always @(negedge clk) begin
        if (rdy0 || rdy1) begin
            chk("one_ready", 32'(rdy0 & rdy1), 32'd0);
            if (q_g1.size() == 0) miss("grant");
            else begin
                e = q_g1.pop_front();
                chk("grant_port", 32'(rdy1), e.v);
                chk("grant_cyc", cyc, e.c);
            end
        end
        if (rb_en) begin
            if (q_bk.size() == 0) miss("bank");
            else begin
                e = q_bk.pop_front();
                chk("bank_access", bk(rb_we, rb_addr, rb_wdata), e.v);
                chk("bank_cyc", cyc, e.c);
            end
        end
        if (rv0) begin
            if (q_r0.size() == 0) miss("rvalid0");
            else begin
                e = q_r0.pop_front();
                chk("rdata0", 32'(rd0), e.v);
                chk("rvalid0_cyc", cyc, e.c);
            end
        end
        if (rv1) begin
            if (q_r1.size() == 0) miss("rvalid1");
            else begin
                e = q_r1.pop_front();
                chk("rdata1", 32'(rd1), e.v);
                chk("rvalid1_cyc", cyc, e.c);
            end
        end
        if (rdy3_0 || rdy3_1) begin
            if (q_g3.size() == 0) miss("grant3");
            else begin
                e = q_g3.pop_front();
                chk("grant3_port", 32'(rdy3_1), e.v);
                chk("grant3_cyc", cyc, e.c);
            end
        end
        if (rv3_1) miss("rvalid3_1");
        if (rv3_0) begin
            if (q_r3.size() == 0) miss("rvalid3_0");
            else begin
                e = q_r3.pop_front();
                chk("rdata3", 32'(rd3_0), e.v);
                chk("rvalid3_cyc", cyc, e.c);
            end
        end
        if (quiet) chk("idle_quiet", 32'({rb_en, rdy0, rdy1, rv0, rv1}), 32'd0);
        if (chk_rst) begin
            chk("rst_ctl", 32'({rdy0, rdy1, rv0, rv1, rb_en, rb_we, rb_addr}), 32'd0);
            chk("rst_data", 32'({rd0, rd1, rb_wdata}), 32'd0);
            chk("rst3_ctl", 32'({rdy3_0, rdy3_1, rv3_0, rv3_1, en3, we3, addr3}), 32'd0);
            chk("rst3_data", 32'({rd3_0, rd3_1, wd3}), 32'd0);
        end
        if (done && !fin) begin
            chk("left_grant", 32'(q_g1.size()), 32'd0);
            chk("left_bank", 32'(q_bk.size()), 32'd0);
            chk("left_r0", 32'(q_r0.size()), 32'd0);
            chk("left_r1", 32'(q_r1.size()), 32'd0);
            chk("left_grant3", 32'(q_g3.size()), 32'd0);
            chk("left_r3", 32'(q_r3.size()), 32'd0);
            fin = 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        {v0, v1, wr0, wr1, v3} = '0;
        {a0, a1, a3} = '0;
        {d0, d1} = '0;
        tick; tick;
        chk_rst = 1'b1;
        tick;
        chk_rst = 1'b0;
        rst_n = 1'b1;
        tick;
        // Simultaneous writes after reset: port 0 first.
        t = cyc;
        v0 = 1; wr0 = 1; a0 = 7'h01; d0 = 8'h11;
        v1 = 1; wr1 = 1; a1 = 7'h02; d1 = 8'h22;
        q_g1.push_back('{t, 0});
        q_g1.push_back('{t + 2, 1});
        q_bk.push_back('{t + 1, bk(1, 7'h01, 8'h11)});
        q_bk.push_back('{t + 3, bk(1, 7'h02, 8'h22)});
        tick; v0 = 0;
        tick; tick; v1 = 0;
        tick;
        // Port 0 write then read back.
        t = cyc;
        v0 = 1; wr0 = 1; a0 = 7'h12; d0 = 8'hA5;
        q_g1.push_back('{t, 0});
        q_bk.push_back('{t + 1, bk(1, 7'h12, 8'hA5)});
        tick; v0 = 0;
        tick;
        v0 = 1; wr0 = 0; a0 = 7'h12; d0 = 8'h00;
        q_g1.push_back('{t + 2, 0});
        q_bk.push_back('{t + 3, bk(0, 7'h12, 8'h00)});
        q_r0.push_back('{t + 5, 32'hA5});
        tick; v0 = 0;
        tick; tick; tick;
        // Continuous contention: prio now favours port 1.
        t = cyc;
        v0 = 1; wr0 = 1; a0 = 7'h20; d0 = 8'hA0;
        v1 = 1; wr1 = 1; a1 = 7'h30; d1 = 8'hB0;
        for (int k = 0; k < 8; k++) begin
            bit p;
            p = (k % 2 == 0);
            q_g1.push_back('{t + 2 * k, 32'(p)});
            q_bk.push_back('{t + 2 * k + 1, bk(1, p ? a1 : a0, p ? d1 : d0)});
            tick;
            if (k == 7) begin
                v0 = 0; v1 = 0;
            end else if (p) begin
                a1 = a1 + 7'd1; d1 = d1 + 8'd1;
            end else begin
                a0 = a0 + 7'd1; d0 = d0 + 8'd1;
            end
            tick;
        end
        quiet = 1'b1;
        repeat (20) tick;
        quiet = 1'b0;
        // Reset while a read sits in RDWAIT; prio is 1 before the reset.
        t = cyc;
        v0 = 1; wr0 = 0; a0 = 7'h01; d0 = 8'h00;
        q_g1.push_back('{t, 0});
        q_bk.push_back('{t + 1, bk(0, 7'h01, 8'h00)});
        tick; v0 = 0;
        tick; rst_n = 1'b0;
        tick; rst_n = 1'b1; chk_rst = 1'b1;
        tick; chk_rst = 1'b0;
        t = cyc;
        v0 = 1; wr0 = 1; a0 = 7'h03; d0 = 8'h33;
        v1 = 1; wr1 = 1; a1 = 7'h04; d1 = 8'h44;
        q_g1.push_back('{t, 0});
        q_g1.push_back('{t + 2, 1});
        q_bk.push_back('{t + 1, bk(1, 7'h03, 8'h33)});
        q_bk.push_back('{t + 3, bk(1, 7'h04, 8'h44)});
        tick; v0 = 0;
        tick; tick; v1 = 0;
        tick;
        // RD_LAT=3 instance: two back-to-back reads from port 0.
        t = cyc;
        v3 = 1; a3 = 7'h33;
        q_g3.push_back('{t, 0});
        q_g3.push_back('{t + 6, 0});
        q_r3.push_back('{t + 5, 32'h5C});
        q_r3.push_back('{t + 11, 32'h5C});
        repeat (7) tick;
        v3 = 0;
        repeat (5) tick;
        done = 1'b1;
        tick; tick;
        if (!fin) begin
            fails++;
            $display("FAIL final_check: monitor never ran end-of-test checks");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
